// File: rtl/adder.sv
// PC-increment adder for the RV32I fetch stage: combinational PC + INCREMENT with carry,
// plus a registered copy of the sum and a sticky wrap flag for pipeline/debug use.
module adder #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned INCREMENT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PCOutput,
    input  logic             en,
    output logic [WIDTH-1:0] AdderOutput,
    output logic             Carry,
    output logic [WIDTH-1:0] AdderOutputQ,
    output logic             WrapSticky
);

    localparam logic [WIDTH:0] INC_EXT = (WIDTH + 1)'(INCREMENT);

    // NOTE: a continuous assign keeps the next-PC path free of latches and of any
    // dependence on clk/rst/en, so it stays valid even when those are undriven.
    assign {Carry, AdderOutput} = {1'b0, PCOutput} + INC_EXT;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of PCOutput regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            AdderOutputQ <= '0;
            WrapSticky   <= 1'b0;
        end else if (en) begin
            AdderOutputQ <= AdderOutput;
            WrapSticky   <= WrapSticky | Carry;
        end
    end

endmodule

// File: tb/tb_adder.sv
// Scoreboard bench for adder: stimulus pushes expected values, a monitor pops and compares
// them once the DUT outputs have settled.
module tb_adder;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] PCOutput;
    logic [31:0] AdderOutput;
    logic        Carry;
    logic [31:0] AdderOutputQ;
    logic        WrapSticky;

    adder #(.WIDTH(32), .INCREMENT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .PCOutput     (PCOutput),
        .en           (en),
        .AdderOutput  (AdderOutput),
        .Carry        (Carry),
        .AdderOutputQ (AdderOutputQ),
        .WrapSticky   (WrapSticky)
    );

    // clk stays X until the registered phase begins
    bit clk_on = 1'b0;
    initial begin
        wait (clk_on);
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        bit          chk_comb;
        logic [31:0] exp_sum;
        logic        exp_carry;
        bit          chk_reg;
        logic [31:0] exp_q;
        logic        exp_sticky;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: outputs have no valid strobe, so each entry is checked one step after it is issued.
    initial begin
        exp_t e;
        forever begin
            wait (sb.size() != 0);
            #1;
            e = sb.pop_front();
            if (e.chk_comb) begin
                check({e.name, ".sum"},   AdderOutput,        e.exp_sum);
                check({e.name, ".carry"}, {31'd0, Carry},     {31'd0, e.exp_carry});
            end
            if (e.chk_reg) begin
                check({e.name, ".q"},      AdderOutputQ,      e.exp_q);
                check({e.name, ".sticky"}, {31'd0, WrapSticky}, {31'd0, e.exp_sticky});
            end
        end
    end

    task automatic drain(input string name);
        int budget = 50;
        while (sb.size() != 0 && budget > 0) begin
            #1;
            budget--;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard not drained, %0d entries left expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic exp_comb(input string name, input logic [31:0] sum, input logic carry);
        exp_t e;
        e = '{name: name, chk_comb: 1'b1, exp_sum: sum, exp_carry: carry,
              chk_reg: 1'b0, exp_q: '0, exp_sticky: 1'b0};
        sb.push_back(e);
        drain(name);
    endtask

    task automatic exp_reg(input string name, input logic [31:0] q, input logic sticky);
        exp_t e;
        e = '{name: name, chk_comb: 1'b0, exp_sum: '0, exp_carry: 1'b0,
              chk_reg: 1'b1, exp_q: q, exp_sticky: sticky};
        sb.push_back(e);
        drain(name);
    endtask

    task automatic exp_both(input string name, input logic [31:0] sum, input logic carry,
                            input logic [31:0] q, input logic sticky);
        exp_t e;
        e = '{name: name, chk_comb: 1'b1, exp_sum: sum, exp_carry: carry,
              chk_reg: 1'b1, exp_q: q, exp_sticky: sticky};
        sb.push_back(e);
        drain(name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pc;
        logic [32:0] ref_sum;

        // Combinational path with clk, rst and en undriven
        PCOutput = 32'd0;
        #10;
        exp_comb("comb_zero", 32'd4, 1'b0);
        PCOutput = 32'd100;
        exp_comb("comb_100", 32'd104, 1'b0);

        PCOutput = 32'hFFFF_FFFC;
        exp_comb("wrap_fffffffc", 32'd0, 1'b1);
        PCOutput = 32'hFFFF_FFFF;
        exp_comb("wrap_ffffffff", 32'd3, 1'b1);
        PCOutput = 32'hFFFF_FFF8;
        exp_comb("wrap_fffffff8", 32'hFFFF_FFFC, 1'b0);

        // Registered path
        rst    = 1'b1;
        en     = 1'b0;
        clk_on = 1'b1;
        tick();
        exp_reg("reset_state", 32'd0, 1'b0);
        tick();
        rst = 1'b0;

        PCOutput = 32'd100;
        en       = 1'b1;
        tick();
        exp_reg("load_104", 32'd104, 1'b0);
        en = 1'b0;

        @(negedge clk);
        rst = 1'b1;
        exp_both("async_reset", 32'd104, 1'b0, 32'd0, 1'b0);
        tick();
        exp_reg("reset_held", 32'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        en       = 1'b1;
        PCOutput = 32'h0000_1000;
        tick();
        exp_reg("capture_1000", 32'h0000_1004, 1'b0);
        en       = 1'b0;
        PCOutput = 32'h0000_2000;
        tick();
        exp_both("hold_en0", 32'h0000_2004, 1'b0, 32'h0000_1004, 1'b0);

        en       = 1'b1;
        PCOutput = 32'hFFFF_FFFC;
        tick();
        exp_reg("sticky_set", 32'd0, 1'b1);
        PCOutput = 32'd8;
        tick();
        exp_reg("sticky_keep", 32'd12, 1'b1);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_reg("sticky_clear", 32'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Random sweep of the combinational path
        for (int i = 0; i < 1000; i++) begin
            pc       = $urandom();
            if (i == 0) pc = 32'hFFFF_FFFD;
            ref_sum  = {1'b0, pc} + 33'd4;
            PCOutput = pc;
            exp_comb("sweep", ref_sum[31:0], ref_sum[32]);
            #2;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
